// File: rtl/pattern_pkg.sv
// Shared pattern definition and FSM state encoding for the pattern stream
// generator and the detector that consumes its stream.
package pattern_pkg;

  localparam int PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PATTERN = 5'b10110;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SEND = 4'b0010,
    ST_GAP  = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

endpackage

// File: rtl/pattern_stream_gen.sv
// Serial burst generator: emits PATTERN (MSB first) num times, separated by
// gap zero-filler bits, with a pause stall and a one-cycle done pulse.
module pattern_stream_gen
  import pattern_pkg::PAT_LEN, pattern_pkg::state_e, pattern_pkg::ST_IDLE,
         pattern_pkg::ST_SEND, pattern_pkg::ST_GAP, pattern_pkg::ST_DONE;
#(
  parameter logic [PAT_LEN-1:0] PATTERN = pattern_pkg::PATTERN,
  parameter int                 CNT_W   = 8,
  parameter int                 GAP_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             pause_i,
  output logic             bit_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_cnt_o
);

  localparam int               IDX_W   = $clog2(PAT_LEN);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_LEN - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_sent;
  logic [CNT_W-1:0]   w_sent_inc;
  logic               w_last;
  logic               w_pat_end;

  assign w_sent_inc = r_sent + CNT_W'(1);
  // Compare against the incremented count so num = 2^CNT_W-1 never wraps.
  assign w_last     = (w_sent_inc == r_num);
  assign w_pat_end  = (r_state == ST_SEND) && !pause_i && (r_idx == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = (num_i == '0) ? ST_DONE : ST_SEND;
      ST_SEND: if (w_pat_end) begin
        if (w_last)             w_state_nxt = ST_DONE;
        else if (r_gap == '0)   w_state_nxt = ST_SEND;
        else                    w_state_nxt = ST_GAP;
      end
      ST_GAP:  if (!pause_i && r_gap_cnt == GAP_W'(1)) w_state_nxt = ST_SEND;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_idx     <= IDX_TOP;
      r_gap_cnt <= '0;
      r_gap     <= '0;
      r_num     <= '0;
      r_sent    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_num  <= num_i;
          r_gap  <= gap_i;
          r_sent <= '0;
          r_idx  <= IDX_TOP;
        end
        ST_SEND: if (!pause_i) begin
          if (r_idx == '0) begin
            r_sent    <= w_sent_inc;
            r_idx     <= IDX_TOP;
            r_gap_cnt <= r_gap;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        ST_GAP: if (!pause_i) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        default: ;
      endcase
    end
  end

  // Pause gates the stream combinationally; everything else decodes from state.
  assign busy_o     = (r_state == ST_SEND) || (r_state == ST_GAP);
  assign valid_o    = busy_o && !pause_i;
  assign bit_o      = (r_state == ST_SEND) && !pause_i && PATTERN[r_idx];
  assign done_o     = (r_state == ST_DONE);
  assign sent_cnt_o = r_sent;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Randomized self-checking bench for pattern_stream_gen with a queue-based
// stream model and a behavioural non-overlapping pattern detector.
module tb_pattern_stream_gen;
  import pattern_pkg::*;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i, start_i, pause_i;
  logic [CNT_W-1:0] num_i;
  logic [GAP_W-1:0] gap_i;
  logic             bit_o, valid_o, busy_o, done_o;
  logic [CNT_W-1:0] sent_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pattern_stream_gen #(.PATTERN(PATTERN), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_i(num_i),
    .gap_i(gap_i), .pause_i(pause_i), .bit_o(bit_o), .valid_o(valid_o),
    .busy_o(busy_o), .done_o(done_o), .sent_cnt_o(sent_cnt_o)
  );

  typedef struct {
    int vcnt;       // unpaused valid cycles
    int paused;     // cycles with pause_i high during the burst
    int viol;       // valid/bit/busy/sent_cnt rule breaks seen mid-burst
    int done_at;    // cycle index of done_o, -1 if never
    int tail;       // done_o/busy_o/valid_o still high the cycle after done
  } obs_t;

  obs_t obs;
  bit   obs_q[$];
  bit   exp_q[$];

  // Expected stream: num copies of the pattern separated by gap zeros.
  function automatic void build_model(input int num, input int gap);
    logic [PAT_LEN-1:0] p;
    p = PATTERN;
    exp_q.delete();
    for (int k = 0; k < num; k++) begin
      for (int b = PAT_LEN - 1; b >= 0; b--) exp_q.push_back(p[b]);
      if (k < num - 1) for (int g = 0; g < gap; g++) exp_q.push_back(1'b0);
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    return (obs_q.size() == exp_q.size()) ? -1 : n;
  endfunction

  // Non-overlapping detector over the observed valid stream.
  function automatic int detect();
    int n = 0;
    int i = 0;
    logic [PAT_LEN-1:0] w;
    while (i + PAT_LEN <= obs_q.size()) begin
      for (int b = 0; b < PAT_LEN; b++) w[PAT_LEN-1-b] = obs_q[i+b];
      if (w == PATTERN) begin n++; i += PAT_LEN; end
      else i++;
    end
    return n;
  endfunction

  // Starts a burst and records what the DUT does until done_o (or stop_after valid bits).
  task automatic run_burst(input int num, input int gap, input int pause_at,
                           input int pause_len, input bit rand_pause, input int stop_after);
    int c = 0;
    int pdone = 0;
    int exp_sent;
    bit pz;
    obs = '{vcnt: 0, paused: 0, viol: 0, done_at: -1, tail: 0};
    obs_q.delete();
    @(negedge clk_i);
    start_i = 1'b1; num_i = CNT_W'(num); gap_i = GAP_W'(gap); pause_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    forever begin
      if (stop_after >= 0 && obs.vcnt == stop_after) break;
      if (c > 4000) break;
      num_i = CNT_W'($urandom);
      gap_i = GAP_W'($urandom);
      if (rand_pause) pz = ($urandom_range(0, 3) == 0);
      else            pz = (pause_at >= 0 && obs.vcnt == pause_at && pdone < pause_len);
      pause_i = pz;
      #1;
      if (!valid_o && bit_o) obs.viol++;
      if (done_o) begin
        obs.done_at = c;
        if (busy_o || valid_o) obs.viol++;
        @(negedge clk_i);
        pause_i = 1'b0;
        #1;
        if (done_o || busy_o || valid_o) obs.tail++;
        break;
      end
      if (!busy_o) obs.viol++;
      exp_sent = (obs.vcnt < PAT_LEN) ? 0 : (obs.vcnt - PAT_LEN) / (PAT_LEN + gap) + 1;
      if (int'(sent_cnt_o) != exp_sent) obs.viol++;
      if (pz) begin
        obs.paused++; pdone++;
        if (valid_o) obs.viol++;
      end else if (valid_o) begin
        obs_q.push_back(bit_o);
        obs.vcnt++;
      end else begin
        obs.viol++;
      end
      c++;
      @(negedge clk_i);
    end
    pause_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1; num_i = 8'd3; gap_i = 4'd1;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (bit_o !== 1'b0) begin failures++; $display("FAIL reset_bit: got %b want 0", bit_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++; if (sent_cnt_o !== '0) begin failures++; $display("FAIL reset_sent: got %0d want 0", sent_cnt_o); end
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_start_dominated: busy got %b want 0", busy_o); end
  endtask

  task automatic test_single();
    run_burst(1, 0, -1, 0, 1'b0, -1);
    build_model(1, 0);
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL single_stream: diff at %0d got len %0d want len %0d", first_diff(), obs_q.size(), exp_q.size()); end
    checks++; if (obs.vcnt != 5) begin failures++; $display("FAIL single_vcnt: got %0d want 5", obs.vcnt); end
    checks++; if (obs.done_at != 5) begin failures++; $display("FAIL single_done_at: got %0d want 5", obs.done_at); end
    checks++; if (sent_cnt_o !== 8'd1) begin failures++; $display("FAIL single_sent: got %0d want 1", sent_cnt_o); end
    checks++; if (obs.viol + obs.tail != 0) begin failures++; $display("FAIL single_rules: got %0d violations want 0", obs.viol + obs.tail); end
  endtask

  task automatic test_gap();
    run_burst(3, 2, -1, 0, 1'b0, -1);
    build_model(3, 2);
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL gap_stream: diff at %0d", first_diff()); end
    checks++; if (obs.vcnt != 19) begin failures++; $display("FAIL gap_vcnt: got %0d want 19", obs.vcnt); end
    checks++; if (detect() != 3) begin failures++; $display("FAIL gap_detect: got %0d want 3", detect()); end
    checks++; if (sent_cnt_o !== 8'd3) begin failures++; $display("FAIL gap_sent: got %0d want 3", sent_cnt_o); end
    checks++; if (obs.viol + obs.tail != 0 || obs.done_at != 19) begin failures++; $display("FAIL gap_rules: viol %0d done_at %0d want 0/19", obs.viol + obs.tail, obs.done_at); end
  endtask

  task automatic test_back_to_back();
    run_burst(4, 0, -1, 0, 1'b0, -1);
    build_model(4, 0);
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL b2b_stream: diff at %0d", first_diff()); end
    checks++; if (obs.vcnt != 20) begin failures++; $display("FAIL b2b_vcnt: got %0d want 20", obs.vcnt); end
    checks++; if (detect() != 4) begin failures++; $display("FAIL b2b_detect: got %0d want 4", detect()); end
    checks++; if (obs.viol + obs.tail != 0 || obs.done_at != 20) begin failures++; $display("FAIL b2b_rules: viol %0d done_at %0d want 0/20", obs.viol + obs.tail, obs.done_at); end
  endtask

  task automatic test_pause();
    run_burst(2, 1, 3, 3, 1'b0, -1);
    build_model(2, 1);
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL pause_stream: diff at %0d", first_diff()); end
    checks++; if (obs.vcnt != 11) begin failures++; $display("FAIL pause_vcnt: got %0d want 11", obs.vcnt); end
    checks++; if (obs.paused != 3) begin failures++; $display("FAIL pause_cycles: got %0d want 3", obs.paused); end
    checks++; if (obs.done_at != 14) begin failures++; $display("FAIL pause_done_at: got %0d want 14", obs.done_at); end
    checks++; if (obs.viol + obs.tail != 0) begin failures++; $display("FAIL pause_rules: got %0d violations want 0", obs.viol + obs.tail); end
  endtask

  task automatic test_zero();
    run_burst(0, 3, -1, 0, 1'b0, -1);
    checks++; if (obs.done_at != 0) begin failures++; $display("FAIL zero_done_at: got %0d want 0", obs.done_at); end
    checks++; if (obs.vcnt != 0) begin failures++; $display("FAIL zero_vcnt: got %0d want 0", obs.vcnt); end
    checks++; if (sent_cnt_o !== '0) begin failures++; $display("FAIL zero_sent: got %0d want 0", sent_cnt_o); end
    checks++; if (obs.viol + obs.tail != 0) begin failures++; $display("FAIL zero_rules: got %0d violations want 0", obs.viol + obs.tail); end
  endtask

  task automatic test_reset_mid_burst();
    int dones = 0;
    run_burst(5, 1, -1, 0, 1'b0, 8);
    checks++; if (obs.vcnt != 8) begin failures++; $display("FAIL midrst_prefix: got %0d valid want 8", obs.vcnt); end
    rst_i = 1'b1; start_i = 1'b1; num_i = 8'd2;
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0;
    #1;
    checks++; if ({valid_o, bit_o, busy_o, done_o} !== 4'b0) begin failures++; $display("FAIL midrst_outputs: got %b want 0000", {valid_o, bit_o, busy_o, done_o}); end
    checks++; if (sent_cnt_o !== '0) begin failures++; $display("FAIL midrst_sent: got %0d want 0", sent_cnt_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      if (done_o || busy_o) dones++;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done: got %0d active cycles want 0", dones); end
    run_burst(1, 0, -1, 0, 1'b0, -1);
    build_model(1, 0);
    checks++; if (first_diff() != -1 || obs.done_at != 5) begin failures++; $display("FAIL midrst_restart: diff %0d done_at %0d want -1/5", first_diff(), obs.done_at); end
    checks++; if (sent_cnt_o !== 8'd1) begin failures++; $display("FAIL midrst_restart_sent: got %0d want 1", sent_cnt_o); end
  endtask

  task automatic test_max_count();
    run_burst(255, 0, -1, 0, 1'b0, -1);
    checks++; if (obs.vcnt != 1275) begin failures++; $display("FAIL max_vcnt: got %0d want 1275", obs.vcnt); end
    checks++; if (sent_cnt_o !== 8'd255) begin failures++; $display("FAIL max_sent: got %0d want 255", sent_cnt_o); end
    checks++; if (obs.done_at != 1275 || obs.viol != 0) begin failures++; $display("FAIL max_done: done_at %0d viol %0d want 1275/0", obs.done_at, obs.viol); end
  endtask

  task automatic test_random();
    int num, gap;
    for (int t = 0; t < 8; t++) begin
      num = $urandom_range(1, 6);
      gap = $urandom_range(0, 3);
      run_burst(num, gap, -1, 0, 1'b1, -1);
      build_model(num, gap);
      checks++; if (first_diff() != -1) begin failures++; $display("FAIL rand%0d_stream: num %0d gap %0d diff at %0d", t, num, gap, first_diff()); end
      checks++; if (detect() != num) begin failures++; $display("FAIL rand%0d_detect: got %0d want %0d", t, detect(), num); end
      checks++; if (int'(sent_cnt_o) != num) begin failures++; $display("FAIL rand%0d_sent: got %0d want %0d", t, sent_cnt_o, num); end
      checks++; if (obs.done_at != exp_q.size() + obs.paused) begin failures++; $display("FAIL rand%0d_done_at: got %0d want %0d", t, obs.done_at, exp_q.size() + obs.paused); end
      checks++; if (obs.viol + obs.tail != 0) begin failures++; $display("FAIL rand%0d_rules: got %0d violations want 0", t, obs.viol + obs.tail); end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; pause_i = 1'b0; num_i = '0; gap_i = '0;
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_pause();
    test_zero();
    test_reset_mid_burst();
    test_max_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_stream_gen.md
PATTERN_STREAM_GEN -- requirements
Module: pattern_stream_gen

Interface
REQ-001 SHALL have parameter PATTERN, default 5'b10110, meaning the 5-bit pattern emitted MSB first.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the pattern-count input and output.
REQ-003 SHALL have parameter GAP_W, default 4, meaning the width of the gap-length input.
REQ-004 clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 start_i  input  1  request to start a burst; sampled only in IDLE.
REQ-007 num_i  input  CNT_W  number of patterns in the burst; captured on an accepted start.
REQ-008 gap_i  input  GAP_W  number of 0 filler bits between consecutive patterns; captured on an accepted start.
REQ-009 pause_i  input  1  stall request; freezes the stream while high.
REQ-010 bit_o  output  1  serial data bit, feeds the detector's in port.
REQ-011 valid_o  output  1  bit_o is meaningful this cycle; feeds the detector's valid_i port.
REQ-012 busy_o  output  1  high in SEND and GAP states.
REQ-013 done_o  output  1  one-cycle pulse when a burst completes.
REQ-014 sent_cnt_o  output  CNT_W  count of complete patterns emitted in the current or last burst.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, SEND, GAP and DONE; all outputs SHALL decode from registers, except for the pause_i gating in REQ-021.
REQ-016 IDLE: on start_i=1 with num_i!=0, the block SHALL latch num_i and gap_i, clear sent_cnt_o, set the bit index to 4, and go to SEND. Latency: the first valid bit is on the cycle after the start edge.
REQ-017 IDLE: on start_i=1 with num_i=0, the block SHALL go to DONE with no valid bits and clear sent_cnt_o.
REQ-018 SEND: valid_o=1 and bit_o=PATTERN[idx]; idx SHALL decrement each unpaused cycle.
REQ-019 At idx=0 in SEND, sent_cnt_o SHALL increment, then:
- if sent_cnt_o equals the latched num, go to DONE;
- else if gap=0, go to SEND with idx=4 (back-to-back patterns);
- else go to GAP with the gap counter loaded to gap.
REQ-020 GAP: valid_o=1 and bit_o=0; the gap counter SHALL decrement each unpaused cycle; on the last gap cycle the FSM SHALL go to SEND with idx=4.
REQ-021 pause_i=1 in SEND or GAP: valid_o=0 and bit_o=0 combinationally; state, idx, gap counter and sent_cnt_o SHALL hold.
REQ-022 DONE: done_o=1 and valid_o=0 for exactly one cycle, then go to IDLE; sent_cnt_o SHALL hold until the next accepted start.
REQ-023 start_i SHALL be ignored in SEND, GAP and DONE; num_i and gap_i changes mid-burst SHALL have no effect.
REQ-024 bit_o SHALL be 0 whenever valid_o=0.
REQ-025 A burst SHALL produce exactly num*5 + (num-1)*gap valid cycles, excluding paused cycles.
REQ-026 The zero filler and leading-1 pattern SHALL guarantee that a non-overlapping detector counts exactly num matches.
REQ-027 num_i = 2^CNT_W-1 SHALL complete without counter wrap.

Reset
REQ-028 rst_i=1 at any clock edge SHALL force IDLE, idx=4, gap counter=0, sent_cnt_o=0, bit_o=0, valid_o=0, busy_o=0 and done_o=0.
REQ-029 Reset mid-burst SHALL abort with no done_o pulse; rst_i SHALL dominate start_i in the same cycle.

Structure
REQ-030 Package pattern_pkg SHALL hold the PATTERN and PAT_LEN=5 constants and the one-hot 4-bit state encoding.
REQ-031 The detector SHALL import pattern_pkg so both ends share one pattern definition.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Bench SHALL cover: num=1, gap=0 -> stream 1,0,1,1,0 with valid_o high for 5 cycles, done_o one cycle later, sent_cnt_o=1.
REQ-034 Bench SHALL cover: num=3, gap=2 -> 19 valid cycles 10110 00 10110 00 10110, detector count=3, sent_cnt_o=3.
REQ-035 Bench SHALL cover: num=4, gap=0 -> 20 back-to-back valid bits, detector count=4.
REQ-036 Bench SHALL cover: num=2, gap=1, pause_i high for 3 cycles at bit 3 -> valid_o low for those 3 cycles, stream resumes with the same bit, total valid cycles=11.
REQ-037 Bench SHALL cover: num=0 -> no valid cycles, done_o on the cycle after start, sent_cnt_o=0.
REQ-038 Bench SHALL cover: num=5, gap=1, rst_i asserted after 8 valid bits -> all outputs 0 next cycle, no done_o, and a new start with num=1 behaves as REQ-033.
